video_sobel_filter: RTL and testbench

Streaming 3x3 Sobel edge-detection stage for the Edge_Detector video path. It sits between the grayscale pixel source (video-in / frame reader) and the VGA pixel-buffer writer. It consumes an 8-bit grayscale Avalon-ST video stream in raster order and emits one 8-bit edge-magnitude pixel per input pixel, with the same packet framing. It holds two line buffers and a 3x3 window, and runs a 2-stage output pipeline with full ready/valid backpressure.

---
 rtl/video_sobel_filter.sv | 166 ++++++++++++++++
 tb/tb_video_sobel_filter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_sobel_filter.sv
// Streaming 3x3 Sobel edge detector for 8-bit grayscale Avalon-ST video.
// Two line buffers feed a 3x3 window; a 2-stage pipeline emits one edge pixel per input pixel.
module video_sobel_filter #(
    parameter int WIDTH     = 320,
    parameter int HEIGHT    = 240,
    parameter int THRESHOLD = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_startofpacket,
    input  logic       in_endofpacket,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_startofpacket,
    output logic       out_endofpacket,
    output logic       out_valid,
    input  logic       out_ready
);
    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    logic [COL_W-1:0]   col_q, col_d, pos_col;
    logic [ROW_W-1:0]   row_q, row_d, pos_row;
    logic [7:0]         lb0_mem [WIDTH];
    logic [7:0]         lb1_mem [WIDTH];
    logic [7:0]         lb0_rd, lb1_rd;
    logic [7:0]         tap_in [3];
    logic [7:0]         win_q [3][2];
    logic [7:0]         win_d [3][2];
    logic signed [10:0] p [3][3];
    logic signed [10:0] gx_q, gx_d, gy_q, gy_d;
    logic               s1_valid_q, s1_valid_d, s1_sop_q, s1_sop_d;
    logic               s1_eop_q, s1_eop_d, s1_border_q, s1_border_d;
    logic               out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
    logic [7:0]         out_data_q, out_data_d;
    logic [10:0]        abs_gx, abs_gy;
    logic [11:0]        mag;
    logic               en, accept;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    assign out_data          = out_data_q;
    assign out_startofpacket = out_sop_q;
    assign out_endofpacket   = out_eop_q;
    assign out_valid         = out_valid_q;

    // SOP pins the accepted pixel to (0,0) whatever the counters say.
    assign pos_col = in_startofpacket ? '0 : col_q;
    assign pos_row = in_startofpacket ? '0 : row_q;

    // Asynchronous reads so the newest column joins the window in the accept cycle.
    assign lb0_rd = lb0_mem[pos_col];
    assign lb1_rd = lb1_mem[pos_col];

    assign tap_in[0] = lb1_rd;
    assign tap_in[1] = lb0_rd;
    assign tap_in[2] = in_data;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
            assign win_d[gi][0] = accept ? win_q[gi][1] : win_q[gi][0];
            assign win_d[gi][1] = accept ? tap_in[gi]   : win_q[gi][1];
            assign p[gi][0]     = signed'({3'b000, win_q[gi][0]});
            assign p[gi][1]     = signed'({3'b000, win_q[gi][1]});
            assign p[gi][2]     = signed'({3'b000, tap_in[gi]});
        end
    endgenerate

    assign abs_gx = gx_q[10] ? 11'(-gx_q) : gx_q;
    assign abs_gy = gy_q[10] ? 11'(-gy_q) : gy_q;
    assign mag    = {1'b0, abs_gx} + {1'b0, abs_gy};

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        gx_d        = gx_q;
        gy_d        = gy_q;
        s1_sop_d    = s1_sop_q;
        s1_eop_d    = s1_eop_q;
        s1_border_d = s1_border_q;
        s1_valid_d  = en ? accept : s1_valid_q;
        if (accept) begin
            if (pos_col == COL_LAST) begin
                col_d = '0;
                row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
            end else begin
                col_d = pos_col + 1'b1;
                row_d = pos_row;
            end
            gx_d = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
            gy_d = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
            s1_sop_d    = in_startofpacket;
            s1_eop_d    = in_endofpacket;
            s1_border_d = (pos_row < ROW_W'(2)) || (pos_col < COL_W'(2));
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_data_d  = out_data_q;
        if (en) begin
            out_valid_d = s1_valid_q;
            out_sop_d   = s1_sop_q;
            out_eop_d   = s1_eop_q;
            if (s1_border_q) begin
                out_data_d = 8'd0;
            end else if (THRESHOLD == 0) begin
                out_data_d = (mag > 12'd255) ? 8'hFF : mag[7:0];
            end else begin
                out_data_d = (int'({20'b0, mag}) > THRESHOLD) ? 8'hFF : 8'h00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col_q       <= '0;
            row_q       <= '0;
            gx_q        <= '0;
            gy_q        <= '0;
            s1_valid_q  <= 1'b0;
            s1_sop_q    <= 1'b0;
            s1_eop_q    <= 1'b0;
            s1_border_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_data_q  <= 8'd0;
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 2; k++) begin
                    win_q[r][k] <= 8'd0;
                end
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            s1_valid_q  <= s1_valid_d;
            s1_sop_q    <= s1_sop_d;
            s1_eop_q    <= s1_eop_d;
            s1_border_q <= s1_border_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_data_q  <= out_data_d;
            win_q       <= win_d;
        end
    end

    // Line-buffer contents are never cleared; the border mask hides stale rows.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_mem[pos_col] <= lb0_rd;
            lb0_mem[pos_col] <= in_data;
        end
    end
endmodule

// File: tb/tb_video_sobel_filter.sv
// Randomized bench for video_sobel_filter: three threshold variants share one stream,
// every output is checked against an image-array Sobel model.
module tb_video_sobel_filter;
    localparam int W = 8;
    localparam int H = 6;

    logic       clk;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_sop, in_eop, in_valid;
    logic       out_ready;
    logic       in_ready0, in_ready200, in_ready500;
    logic [7:0] out_data0, out_data200, out_data500;
    logic       out_sop0, out_sop200, out_sop500;
    logic       out_eop0, out_eop200, out_eop500;
    logic       out_valid0, out_valid200, out_valid500;

    video_sobel_filter #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data),
        .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_valid(in_valid),
        .in_ready(in_ready0), .out_data(out_data0), .out_startofpacket(out_sop0),
        .out_endofpacket(out_eop0), .out_valid(out_valid0), .out_ready(out_ready));

    video_sobel_filter #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(200)) u_dut200 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data),
        .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_valid(in_valid),
        .in_ready(in_ready200), .out_data(out_data200), .out_startofpacket(out_sop200),
        .out_endofpacket(out_eop200), .out_valid(out_valid200), .out_ready(out_ready));

    video_sobel_filter #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(500)) u_dut500 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data),
        .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_valid(in_valid),
        .in_ready(in_ready500), .out_data(out_data500), .out_startofpacket(out_sop500),
        .out_endofpacket(out_eop500), .out_valid(out_valid500), .out_ready(out_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d0, d1, d2;
        logic       sop, eop;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         img [H][W];
    int         mr = 0, mc = 0;
    int         total = 0, bad = 0;
    int         ready_mode = 1;
    int         gap_pct = 0;
    int         negcnt = 0, lat_acc = -1, out_cnt = 0;
    bit         lat_arm = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data;
    logic [1:0] prev_flags;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int ref_pix(input int r, input int c, input int thr);
        int gx, gy, mag;
        if (r < 2 || c < 2) return 0;
        gx = (img[r-2][c] + 2 * img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2 * img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2 * img[r][c-1] + img[r][c])
           - (img[r-2][c-2] + 2 * img[r-2][c-1] + img[r-2][c]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (thr == 0) return (mag > 255) ? 255 : mag;
        return (mag > thr) ? 255 : 0;
    endfunction

    function automatic void model_accept();
        int   r, c;
        exp_t e;
        r = in_sop ? 0 : mr;
        c = in_sop ? 0 : mc;
        img[r][c] = int'(in_data);
        e.d0  = 8'(ref_pix(r, c, 0));
        e.d1  = 8'(ref_pix(r, c, 200));
        e.d2  = 8'(ref_pix(r, c, 500));
        e.sop = in_sop;
        e.eop = in_eop;
        exp_q.push_back(e);
        if (c == W - 1) begin
            mc = 0;
            mr = (r == H - 1) ? 0 : r + 1;
        end else begin
            mc = c + 1;
            mr = r;
        end
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            mr = 0;
            mc = 0;
            prev_stall = 0;
        end else begin
            chk("in_ready_rule", in_ready0, !out_valid0 || out_ready);
            chk("inst_agree", {out_valid200, out_valid500, in_ready200, in_ready500},
                {out_valid0, out_valid0, in_ready0, in_ready0});
            if (prev_stall) begin
                chk("hold_valid", out_valid0, 1);
                chk("hold_data", out_data0, prev_data);
                chk("hold_flags", {out_sop0, out_eop0}, prev_flags);
            end
            if (out_valid0 && out_ready) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL extra_output observed=%0d expected=none", out_data0);
                end
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    $display("out #%0d data=%0d/%0d/%0d sop=%0b eop=%0b", out_cnt,
                             out_data0, out_data200, out_data500, out_sop0, out_eop0);
                    out_cnt++;
                    chk("data_thr0", out_data0, mon_e.d0);
                    chk("data_thr200", out_data200, mon_e.d1);
                    chk("data_thr500", out_data500, mon_e.d2);
                    chk("sop", {out_sop0, out_sop200, out_sop500}, {3{mon_e.sop}});
                    chk("eop", {out_eop0, out_eop200, out_eop500}, {3{mon_e.eop}});
                end
            end
            if (lat_arm && lat_acc >= 0 && out_valid0) begin
                chk("latency", negcnt - lat_acc, 2);
                lat_arm = 0;
            end
            if (in_valid && in_ready0) begin
                model_accept();
                if (lat_arm && lat_acc < 0) lat_acc = negcnt;
            end
            prev_stall = out_valid0 && !out_ready;
            prev_data  = out_data0;
            prev_flags = {out_sop0, out_eop0};
        end
        negcnt++;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    function automatic logic [7:0] pat(input int mode, input int idx);
        int c;
        c = idx % W;
        case (mode)
            0:       return 8'd77;
            1:       return (c >= 4) ? 8'd10 : 8'd0;
            2:       return (c >= 4) ? 8'd100 : 8'd0;
            3:       return 8'($urandom_range(0, 255));
            default: return 8'($urandom_range(0, 60));
        endcase
    endfunction

    // Caller must be at posedge+1; returns at posedge+1 after the pixel is taken.
    task automatic send(input logic [7:0] d, input logic s, input logic e);
        int   n;
        logic acc;
        while ($urandom_range(0, 99) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready0;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 1000) begin
                total++;
                bad++;
                $error("FAIL send_timeout observed=stalled expected=accept");
                break;
            end
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic send_frame(input int mode);
        for (int i = 0; i < W * H; i++) begin
            send(pat(mode, i), i == 0, i == W * H - 1);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        in_data  = 8'd0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_data", out_data0, 0);
        chk("rst_out_sop", out_sop0, 0);
        chk("rst_out_eop", out_eop0, 0);
        chk("rst_in_ready", in_ready0, 1);
        @(posedge clk);
        #1;

        // directed frames: uniform, small step, saturating step
        lat_arm = 1;
        send_frame(0);
        send_frame(1);
        send_frame(2);

        // random stalls and gaps over back-to-back frames
        ready_mode = 2;
        gap_pct    = 30;
        send_frame(4);
        send_frame(3);
        send_frame(4);
        ready_mode = 1;
        gap_pct    = 0;

        // SOP reasserted at pixel 20
        for (int i = 0; i < 20; i++) send(pat(4, i), i == 0, 1'b0);
        for (int i = 0; i < W * H; i++) send(pat(4, i), i == 0, i == W * H - 1);

        // reset mid-frame while output is stalled
        for (int i = 0; i < 10; i++) send(pat(3, i), i == 0, 1'b0);
        ready_mode = 0;
        @(negedge clk);
        chk("pre_reset_valid", out_valid0, 1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_valid", out_valid0, 0);
        chk("post_reset_in_ready", in_ready0, 1);
        ready_mode = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < W * H; i++) send(pat(4, i), 1'b0, i == W * H - 1);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
        chk("latency_seen", lat_arm, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
